// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator: hall synchronisation and debounce, sector decode,
// direction-dependent switch table, PWM gating of the high sides, per-phase
// dead time and hall-edge period measurement.
// Optional feature macro: BLDC_BRAKE_EN adds a 'brake' input that requests all
// low sides on (dead time still applies, hall_fault still forces gates off).
module bldc_commutator #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned DEADTIME  = 8,
    parameter int unsigned PER_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [2:0]       hall_in,
    input  logic             dir,
    input  logic             pwm_in,
`ifdef BLDC_BRAKE_EN
    input  logic             brake,
`endif
    output logic [2:0]       gate_h,
    output logic [2:0]       gate_l,
    output logic [2:0]       sector,
    output logic             hall_fault,
    output logic [PER_W-1:0] period,
    output logic             period_valid
);

    localparam int unsigned DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam int unsigned DTW = (DEADTIME > 1) ? $clog2(DEADTIME + 1) : 1;

    logic [2:0]       hall_s1_q, hall_s2_q, hall_db_q, cand_q, cand_d, hall_db_d;
    logic [DBW-1:0]   db_cnt_q, db_cnt_d, held;
    logic             accept;
    logic [2:0]       sector_q, dec_db, dec_new, step;
    logic             valid_db, valid_new;
    logic [PER_W-1:0] per_cnt_q;
    logic [2:0]       tab_h, tab_l, req_h, req_l;
    logic [2:0]       gate_h_q, gate_l_q, gate_h_d, gate_l_d;
    logic [DTW-1:0]   dt_h_q [3];
    logic [DTW-1:0]   dt_l_q [3];
    logic [DTW-1:0]   dt_h_d [3];
    logic [DTW-1:0]   dt_l_d [3];
    logic             brake_w;

`ifdef BLDC_BRAKE_EN
    assign brake_w = brake;
`else
    assign brake_w = 1'b0;
`endif

    // Returns {valid, sector} for a hall code.
    function automatic logic [3:0] decode(input logic [2:0] h);
        unique case (h)
            3'b101:  decode = {1'b1, 3'd0};
            3'b100:  decode = {1'b1, 3'd1};
            3'b110:  decode = {1'b1, 3'd2};
            3'b010:  decode = {1'b1, 3'd3};
            3'b011:  decode = {1'b1, 3'd4};
            3'b001:  decode = {1'b1, 3'd5};
            default: decode = {1'b0, 3'd0};
        endcase
    endfunction

    // Debounce: held counts consecutive cycles the synchronised value has differed.
    always_comb begin
        cand_d    = hall_s2_q;
        hall_db_d = hall_db_q;
        accept    = 1'b0;
        held      = (hall_s2_q != cand_q) ? DBW'(1) : db_cnt_q + DBW'(1);
        db_cnt_d  = held;
        if (hall_s2_q == hall_db_q) begin
            db_cnt_d = '0;
        end else if (held >= DBW'(DB_CYCLES)) begin
            accept    = 1'b1;
            hall_db_d = hall_s2_q;
            db_cnt_d  = '0;
        end
    end

    // Synchroniser, debounce state and period measurement registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hall_s1_q    <= '0;
            hall_s2_q    <= '0;
            cand_q       <= '0;
            hall_db_q    <= '0;
            db_cnt_q     <= '0;
            sector_q     <= '0;
            per_cnt_q    <= '0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            hall_s1_q    <= hall_in;
            hall_s2_q    <= hall_s1_q;
            cand_q       <= cand_d;
            hall_db_q    <= hall_db_d;
            db_cnt_q     <= db_cnt_d;
            sector_q     <= sector;
            period_valid <= 1'b0;
            if (accept && valid_db && valid_new) begin
                period       <= per_cnt_q;
                period_valid <= 1'b1;
                per_cnt_q    <= PER_W'(1);
            end else if (per_cnt_q != '1) begin
                per_cnt_q <= per_cnt_q + PER_W'(1);
            end
        end
    end

    assign {valid_db, dec_db}   = decode(hall_db_q);
    assign {valid_new, dec_new} = decode(hall_s2_q);
    assign hall_fault           = ~valid_db;
    // Sector follows the accepted value immediately and holds through faults.
    assign sector               = valid_db ? dec_db : sector_q;

    // Step selection, switch table and request gating.
    always_comb begin
        step = sector;
        if (dir) begin
            step = (sector >= 3'd3) ? sector - 3'd3 : sector + 3'd3;
        end
        tab_h = 3'b000;
        tab_l = 3'b000;
        case (step)
            3'd0:    begin tab_h = 3'b001; tab_l = 3'b010; end
            3'd1:    begin tab_h = 3'b001; tab_l = 3'b100; end
            3'd2:    begin tab_h = 3'b010; tab_l = 3'b100; end
            3'd3:    begin tab_h = 3'b010; tab_l = 3'b001; end
            3'd4:    begin tab_h = 3'b100; tab_l = 3'b001; end
            3'd5:    begin tab_h = 3'b100; tab_l = 3'b010; end
            default: begin tab_h = 3'b000; tab_l = 3'b000; end
        endcase
        req_h = 3'b000;
        req_l = 3'b000;
        if (hall_fault) begin
            req_h = 3'b000;
            req_l = 3'b000;
        end else if (brake_w) begin
            req_l = 3'b111;
        end else if (ena) begin
            req_h = tab_h & {3{pwm_in}};
            req_l = tab_l;
        end
    end

    // Dead time: a switch may rise on the edge where the opposite counter reaches 0,
    // and never while the opposite switch is still on.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            gate_h_d[i] = req_h[i] & ~gate_l_q[i] & (dt_l_q[i] <= DTW'(1));
            gate_l_d[i] = req_l[i] & ~gate_h_q[i] & (dt_h_q[i] <= DTW'(1));
            dt_h_d[i]   = (dt_h_q[i] != '0) ? dt_h_q[i] - DTW'(1) : '0;
            dt_l_d[i]   = (dt_l_q[i] != '0) ? dt_l_q[i] - DTW'(1) : '0;
            if (gate_h_q[i] && !gate_h_d[i]) begin
                dt_h_d[i] = DTW'(DEADTIME);
            end
            if (gate_l_q[i] && !gate_l_d[i]) begin
                dt_l_d[i] = DTW'(DEADTIME);
            end
        end
    end

    // Gate and dead-time registers; reset drops all gates at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_h_q <= '0;
            gate_l_q <= '0;
            for (int i = 0; i < 3; i++) begin
                dt_h_q[i] <= DTW'(DEADTIME);
                dt_l_q[i] <= DTW'(DEADTIME);
            end
        end else begin
            gate_h_q <= gate_h_d;
            gate_l_q <= gate_l_d;
            for (int i = 0; i < 3; i++) begin
                dt_h_q[i] <= dt_h_d[i];
                dt_l_q[i] <= dt_l_d[i];
            end
        end
    end

    assign gate_h = gate_h_q;
    assign gate_l = gate_l_q;

endmodule

// File: tb/tb_bldc_commutator.sv
// Self-checking bench for bldc_commutator (DB_CYCLES=4, DEADTIME=8, PER_W=16).
module tb_bldc_commutator;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [2:0]  hall_in;
    logic        dir;
    logic        pwm_in;
`ifdef BLDC_BRAKE_EN
    logic        brake;
`endif
    logic [2:0]  gate_h, gate_l, sector;
    logic        hall_fault;
    logic [15:0] period;
    logic        period_valid;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] hall;
        logic       dir;
        logic       pwm;
        logic       ena;
        logic [2:0] sec;
        logic [2:0] gh;
        logic [2:0] gl;
        logic       flt;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    bldc_commutator #(
        .DB_CYCLES(4),
        .DEADTIME (8),
        .PER_W    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .hall_in     (hall_in),
        .dir         (dir),
        .pwm_in      (pwm_in),
`ifdef BLDC_BRAKE_EN
        .brake       (brake),
`endif
        .gate_h      (gate_h),
        .gate_l      (gate_l),
        .sector      (sector),
        .hall_fault  (hall_fault),
        .period      (period),
        .period_valid(period_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    initial begin
        int pv_seen;
        int overlap;
        int pulses;
        logic [15:0] per_cap;
        logic [2:0] seq [6];

        seq[0] = 3'b101; seq[1] = 3'b100; seq[2] = 3'b110;
        seq[3] = 3'b010; seq[4] = 3'b011; seq[5] = 3'b001;

        //            hall    dir   pwm   ena   sec   gh      gl      flt
        vecs[0]  = '{3'b101, 1'b0, 1'b1, 1'b1, 3'd0, 3'b001, 3'b010, 1'b0};
        vecs[1]  = '{3'b100, 1'b0, 1'b1, 1'b1, 3'd1, 3'b001, 3'b100, 1'b0};
        vecs[2]  = '{3'b110, 1'b0, 1'b1, 1'b1, 3'd2, 3'b010, 3'b100, 1'b0};
        vecs[3]  = '{3'b010, 1'b0, 1'b1, 1'b1, 3'd3, 3'b010, 3'b001, 1'b0};
        vecs[4]  = '{3'b011, 1'b0, 1'b1, 1'b1, 3'd4, 3'b100, 3'b001, 1'b0};
        vecs[5]  = '{3'b001, 1'b0, 1'b1, 1'b1, 3'd5, 3'b100, 3'b010, 1'b0};
        vecs[6]  = '{3'b001, 1'b1, 1'b1, 1'b1, 3'd5, 3'b010, 3'b100, 1'b0};
        vecs[7]  = '{3'b101, 1'b1, 1'b1, 1'b1, 3'd0, 3'b010, 3'b001, 1'b0};
        vecs[8]  = '{3'b100, 1'b1, 1'b0, 1'b1, 3'd1, 3'b000, 3'b001, 1'b0};
        vecs[9]  = '{3'b100, 1'b0, 1'b1, 1'b0, 3'd1, 3'b000, 3'b000, 1'b0};
        vecs[10] = '{3'b111, 1'b0, 1'b1, 1'b1, 3'd1, 3'b000, 3'b000, 1'b1};
        vecs[11] = '{3'b000, 1'b0, 1'b1, 1'b1, 3'd1, 3'b000, 3'b000, 1'b1};
        vecs[12] = '{3'b110, 1'b0, 1'b1, 1'b1, 3'd2, 3'b010, 3'b100, 1'b0};

        rst = 1'b1; ena = 1'b1; hall_in = 3'b000; dir = 1'b0; pwm_in = 1'b1;
`ifdef BLDC_BRAKE_EN
        brake = 1'b0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_gate_h", gate_h, 3'b000);
        chk("rst_gate_l", gate_l, 3'b000);
        chk("rst_fault", hall_fault, 1'b1);
        chk("rst_sector", sector, 3'd0);
        chk("rst_period", period, 16'd0);
        chk("rst_pvalid", period_valid, 1'b0);

        // First valid hall: 2+DB_CYCLES latency, gates one cycle later
        repeat (10) tick();
        hall_in = 3'b101;
        repeat (5) tick();
        chk("lat5_fault", hall_fault, 1'b1);
        tick();
        chk("lat6_fault", hall_fault, 1'b0);
        chk("lat6_sector", sector, 3'd0);
        chk("lat6_gate_h", gate_h, 3'b000);
        tick();
        chk("on_gate_h", gate_h, 3'b001);
        chk("on_gate_l", gate_l, 3'b010);
        pwm_in = 1'b0;
        tick();
        chk("pwm0_gate_h", gate_h, 3'b000);
        chk("pwm0_gate_l", gate_l, 3'b010);
        pwm_in = 1'b1;
        tick();
        chk("pwm1_gate_h", gate_h, 3'b001);

        // 3-cycle glitch is rejected, 4-cycle pulse is accepted
        pv_seen = 0;
        hall_in = 3'b100;
        repeat (3) tick();
        hall_in = 3'b101;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (period_valid) pv_seen++;
            if (sector != 3'd0) pv_seen += 100;
        end
        chk("glitch_rejected", pv_seen, 0);
        hall_in = 3'b100;
        repeat (4) tick();
        hall_in = 3'b101;
        repeat (2) tick();
        chk("pulse4_sector", sector, 3'd1);
        chk("pulse4_pvalid", period_valid, 1'b1);
        repeat (20) tick();
        chk("back_sector0", sector, 3'd0);
        chk("back_gate_h", gate_h, 3'b001);
        chk("back_gate_l", gate_l, 3'b010);

        // Direction reversal in sector 0: dead time on phases A and B
        dir = 1'b1;
        overlap = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if ((gate_h & gate_l) != 3'b000) overlap++;
            if (t == 1) begin
                chk("rev_t1_gate_h", gate_h, 3'b000);
                chk("rev_t1_gate_l", gate_l, 3'b000);
            end
            if (t == 8) begin
                chk("rev_t8_gate_h", gate_h, 3'b000);
                chk("rev_t8_gate_l", gate_l, 3'b000);
            end
            if (t == 9) begin
                chk("rev_t9_gate_h", gate_h, 3'b010);
                chk("rev_t9_gate_l", gate_l, 3'b001);
            end
        end
        chk("rev_no_overlap", overlap, 0);

        // Table-driven steady-state vectors
        for (int v = 0; v < 13; v++) begin
            hall_in = vecs[v].hall;
            dir     = vecs[v].dir;
            pwm_in  = vecs[v].pwm;
            ena     = vecs[v].ena;
            overlap = 0;
            for (int t = 0; t < 20; t++) begin
                tick();
                if ((gate_h & gate_l) != 3'b000) overlap++;
            end
            chk($sformatf("vec%0d_sector", v), sector, vecs[v].sec);
            chk($sformatf("vec%0d_gate_h", v), gate_h, vecs[v].gh);
            chk($sformatf("vec%0d_gate_l", v), gate_l, vecs[v].gl);
            chk($sformatf("vec%0d_fault", v), hall_fault, vecs[v].flt);
            chk($sformatf("vec%0d_overlap", v), overlap, 0);
        end

        // Period: steps every 1000 cycles, starting from sector 2 (hall 110)
        ena = 1'b1; pwm_in = 1'b1; dir = 1'b0;
        for (int k = 0; k < 4; k++) begin
            hall_in = seq[(3 + k) % 6];
            pulses  = 0;
            per_cap = '0;
            for (int t = 0; t < 1000; t++) begin
                tick();
                if (period_valid) begin
                    pulses++;
                    per_cap = period;
                end
            end
            chk($sformatf("per_step%0d_pulses", k), pulses, 1);
            if (k > 0) chk($sformatf("per_step%0d_value", k), per_cap, 16'd1000);
        end
        // Stall: counter saturates
        repeat (70000) tick();
        hall_in = seq[1];
        pulses  = 0;
        per_cap = '0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (period_valid) begin
                pulses++;
                per_cap = period;
            end
        end
        chk("stall_pulses", pulses, 1);
        chk("stall_period", per_cap, 16'd65535);

        // Hall fault while driving
        repeat (20) tick();
        hall_in = 3'b111;
        repeat (5) tick();
        chk("flt5_fault", hall_fault, 1'b0);
        tick();
        chk("flt6_fault", hall_fault, 1'b1);
        chk("flt6_gate_l", gate_l, 3'b100);
        tick();
        chk("flt7_gate_h", gate_h, 3'b000);
        chk("flt7_gate_l", gate_l, 3'b000);

`ifdef BLDC_BRAKE_EN
        hall_in = 3'b101;
        brake   = 1'b1;
        ena     = 1'b0;
        repeat (25) tick();
        chk("brake_gate_h", gate_h, 3'b000);
        chk("brake_gate_l", gate_l, 3'b111);
        hall_in = 3'b000;
        repeat (8) tick();
        chk("brake_fault_gate_l", gate_l, 3'b000);
        brake = 1'b0;
        ena   = 1'b1;
`endif

        // Asynchronous reset mid-operation drops gates without a clock edge
        hall_in = 3'b101;
        repeat (25) tick();
        chk("pre_rst_gate_l", gate_l, 3'b010);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_gate_h", gate_h, 3'b000);
        chk("async_rst_gate_l", gate_l, 3'b000);
        tick();
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bldc_commutator.md
Name: bldc_commutator

Overview:
- Six-step commutation stage between the hall-sensor pins and the gate-drive outputs of the BLDC controller top level.
- Synchronises and debounces the three hall inputs, decodes them to a rotor sector, and selects the high/low switch pattern for the requested direction.
- Gates the high sides with the upstream PWM signal and inserts per-phase dead time.
- Measures the hall-edge period for the speed loop.

Parameters:
- DB_CYCLES, 4: consecutive cycles a synchronised hall value must hold before it is accepted.
- DEADTIME, 8: minimum cycles between one switch of a phase turning off and the opposite switch of that phase turning on.
- PER_W, 16: width of the hall period counter.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  drive enable; 0 forces all gates off.
- hall_in  in  3  raw hall sensors {C,B,A}; asynchronous to clk.
- dir  in  1  0 = forward, 1 = reverse.
- pwm_in  in  1  PWM from upstream generator; gates the high sides.
- gate_h  out  3  high-side gate drives {C,B,A}; registered.
- gate_l  out  3  low-side gate drives {C,B,A}; registered.
- sector  out  3  current rotor sector, 0..5.
- hall_fault  out  1  debounced hall value is 000 or 111.
- period  out  PER_W  clk cycles between the last two valid sector changes.
- period_valid  out  1  one-cycle pulse when period updates.

Behaviour:
- Reset values:
  - gate_h = 000, gate_l = 000.
  - sector = 0, period = 0, period_valid = 0.
  - Debounced hall = 000, so hall_fault = 1 until the first valid value is accepted.
  - Dead-time counters load DEADTIME, so no gate turns on for DEADTIME cycles after reset release.
  - Reset asserted mid-operation drops all gates immediately (asynchronous).
- Sync: 2-FF synchroniser per hall bit.
- Debounce:
  - A candidate value that differs from the accepted value must hold for DB_CYCLES consecutive cycles; it is accepted on the following edge.
  - If the candidate changes before then, the count restarts.
  - Total latency from a hall_in change to the accepted value is 2+DB_CYCLES cycles.
- Decode: 101→0, 100→1, 110→2, 010→3, 011→4, 001→5. Values 000 and 111 set hall_fault; sector holds its last valid value.
- Step = sector when dir=0; step = (sector+3) mod 6 when dir=1. Step table (high, low):
  - 0: A, B
  - 1: A, C
  - 2: B, C
  - 3: B, A
  - 4: C, A
  - 5: C, B
- Requests:
  - High request = table high AND pwm_in.
  - Low request = table low; the low side is held on, not complementary.
  - All requests are 0 when ena=0 or hall_fault=1.
- Dead time, per phase with two counters:
  - When the high side turns off, dt_h loads DEADTIME and blocks the low side until it reaches 0. dt_l blocks the high side the same way.
  - A request is registered onto the gate one cycle after it occurs, provided the blocking counter is 0.
  - Turn-off is never delayed: the gate falls one cycle after its request drops.
  - Both switches of one phase are never on in the same cycle.
- Period measurement:
  - Free-running counter that saturates at 2^PER_W−1; saturation indicates a stall.
  - On each accepted valid sector change: period ← counter, period_valid = 1 for one cycle, counter ← 1.
  - A change to or from an invalid hall value does not update period.

Optional Feature:
- Macro: BLDC_BRAKE_EN.
- Defined:
  - Adds input port brake (1 bit).
  - brake=1 with hall_fault=0 requests all low sides on and all high sides off, regardless of ena, sector and pwm_in.
  - Dead time still applies; hall_fault still forces all gates off.
- Undefined: no brake port; behaviour is identical to brake=0.

Test Plan (DB_CYCLES=4, DEADTIME=8):
- Reset release, hall_in=000 → gates 000/000, hall_fault=1, period=0, period_valid=0.
- hall_in=101, ena=1, pwm_in=1, dir=0, applied more than 8 cycles after reset → 6 cycles later hall_fault=0, sector=0; next cycle gate_h=001, gate_l=010; pwm_in=0 → gate_h=000 one cycle later.
- hall_in 101 steady with a 3-cycle 100 glitch → sector stays 0 and period_valid never pulses; a 4-cycle 100 pulse → sector=1.
- In sector 0, toggle dir 0→1 →
  - A high and B low turn off after 1 cycle.
  - A low and B high both turn on 8 cycles after their opposite switch dropped.
  - Check every cycle that the high and low sides of one phase are never both 1.
- Valid hall steps every 1000 cycles → period=1000 with one-cycle period_valid per step; holding the hall for 70000 cycles → period=65535 on the next step.
- hall_in=111 while driving → 6 cycles later hall_fault=1, then all gates 000; with BLDC_BRAKE_EN and brake=1 in a valid sector → gate_h=000 and gate_l=111 once dead time expires.
